// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin Avalon-MM arbiter for a single-port on-chip RAM, with a zero-fill clear sequencer.
// Optional address range checking is enabled by defining ONCHIP_MEM_ARB_RANGE_CHECK_EN.
module onchip_mem_arbiter #(
   parameter int                ADDR_W      = 13,
   parameter int                DATA_W      = 32,
   parameter int                DEPTH       = 6250,
   parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     m0_address,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W-1:0]     m0_writedata,
   output logic                  m0_waitrequest,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_readdatavalid,
   input  logic [ADDR_W-1:0]     m1_address,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W-1:0]     m1_writedata,
   output logic                  m1_waitrequest,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_readdatavalid,
   input  logic                  clear_req,
   output logic                  clear_busy,
   output logic                  clear_done,
   output logic                  range_err,
   output logic [ADDR_W-1:0]     mem_address,
   output logic [DATA_W/8-1:0]   mem_byteenable,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic [DATA_W-1:0]     mem_writedata,
   output logic                  mem_clken,
   input  logic [DATA_W-1:0]     mem_readdata
);

   localparam int                BE_W    = DATA_W/8;
   localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(DEPTH-1);

   typedef enum logic {ST_ARB, ST_CLEAR} state_t;

   state_t            r_state;
   logic              r_rr_last;
   logic              r_rd_pend;
   logic              r_rd_owner;
   logic              r_clear_done;
   logic [ADDR_W-1:0] r_cnt;

   logic              w_req0;
   logic              w_req1;
   logic              w_gnt_any;
   logic              w_gnt_id;
   logic              w_rd_gnt;
   logic              w_fwd;
   logic              w_clr;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [BE_W-1:0]   w_sel_be;
   logic              w_sel_read;
   logic              w_sel_write;
   logic [DATA_W-1:0] w_sel_wdata;
   logic [DATA_W-1:0] w_rd_data;

`ifdef ONCHIP_MEM_ARB_RANGE_CHECK_EN
   localparam logic [ADDR_W:0]   LP_DEPTH    = DEPTH[ADDR_W:0];
   localparam logic [DATA_W-1:0] LP_OOR_DATA = DATA_W'(32'hDEADBEEF);
   logic r_rd_oor;
   logic r_range_err;
   logic w_oor;
`endif

   always_comb begin
      w_req0      = m0_read | m0_write;
      w_req1      = m1_read | m1_write;
      // Clear request and reset both pre-empt any grant in the current cycle.
      w_gnt_any   = !reset && (r_state == ST_ARB) && !clear_req && (w_req0 || w_req1);
      w_gnt_id    = (w_req0 && w_req1) ? ~r_rr_last : w_req1;
      w_sel_addr  = w_gnt_id ? m1_address    : m0_address;
      w_sel_be    = w_gnt_id ? m1_byteenable : m0_byteenable;
      w_sel_read  = w_gnt_id ? m1_read       : m0_read;
      w_sel_write = w_gnt_id ? m1_write      : m0_write;
      w_sel_wdata = w_gnt_id ? m1_writedata  : m0_writedata;
      w_rd_gnt    = w_gnt_any && w_sel_read && !w_sel_write;
      w_clr       = !reset && (r_state == ST_CLEAR);
`ifdef ONCHIP_MEM_ARB_RANGE_CHECK_EN
      w_oor       = ({1'b0, w_sel_addr} >= LP_DEPTH);
      w_fwd       = w_gnt_any && !w_oor;
      w_rd_data   = r_rd_oor ? LP_OOR_DATA : mem_readdata;
`else
      w_fwd       = w_gnt_any;
      w_rd_data   = mem_readdata;
`endif
   end

   assign m0_waitrequest   = !(w_gnt_any && !w_gnt_id);
   assign m1_waitrequest   = !(w_gnt_any &&  w_gnt_id);
   assign m0_readdatavalid = r_rd_pend && !r_rd_owner;
   assign m1_readdatavalid = r_rd_pend &&  r_rd_owner;
   assign m0_readdata      = m0_readdatavalid ? w_rd_data : '0;
   assign m1_readdata      = m1_readdatavalid ? w_rd_data : '0;

   assign mem_chipselect   = w_clr | w_fwd;
   assign mem_write        = w_clr | (w_fwd && w_sel_write);
   assign mem_address      = w_clr ? r_cnt        : w_sel_addr;
   assign mem_byteenable   = w_clr ? {BE_W{1'b1}} : w_sel_be;
   assign mem_writedata    = w_clr ? CLEAR_VALUE  : w_sel_wdata;
   assign mem_clken        = !reset;

   assign clear_busy       = (r_state == ST_CLEAR);
   assign clear_done       = r_clear_done;
`ifdef ONCHIP_MEM_ARB_RANGE_CHECK_EN
   assign range_err        = r_range_err;
`else
   assign range_err        = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_ARB;
         r_rr_last    <= 1'b1;
         r_rd_pend    <= 1'b0;
         r_rd_owner   <= 1'b0;
         r_clear_done <= 1'b0;
         r_cnt        <= '0;
`ifdef ONCHIP_MEM_ARB_RANGE_CHECK_EN
         r_rd_oor     <= 1'b0;
         r_range_err  <= 1'b0;
`endif
      end else begin
         r_rd_pend    <= w_rd_gnt;
         r_clear_done <= 1'b0;
         if (w_gnt_any) begin
            r_rr_last  <= w_gnt_id;
            r_rd_owner <= w_gnt_id;
         end
`ifdef ONCHIP_MEM_ARB_RANGE_CHECK_EN
         r_rd_oor <= w_rd_gnt && w_oor;
         if (w_gnt_any && w_oor)
            r_range_err <= 1'b1;
`endif
         case (r_state)
            ST_ARB: begin
               if (clear_req) begin
                  r_state <= ST_CLEAR;
                  r_cnt   <= '0;
               end
            end
            ST_CLEAR: begin
               if (r_cnt == LP_LAST) begin
                  r_state      <= ST_ARB;
                  r_cnt        <= '0;
                  r_clear_done <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= ST_ARB;
         endcase
      end
   end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Scoreboard bench for onchip_mem_arbiter with a behavioural single-port RAM behind it.
// Define ONCHIP_MEM_ARB_RANGE_CHECK_EN to exercise the range-check build.
module tb_onchip_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [12:0] m0_address, m1_address;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic        clear_req, clear_busy, clear_done, range_err;
   logic [12:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect, mem_write, mem_clken;
   logic [31:0] mem_writedata, mem_readdata;

   onchip_mem_arbiter dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
      .range_err(range_err),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
   );

   always #5 clk = ~clk;

   // RAM: registered address, unregistered read data
   logic [31:0] ram [0:6249];
   logic [12:0] ram_a = '0;
   initial for (int i = 0; i < 6250; i++) ram[i] = 32'h0;
   always @(posedge clk) begin
      if (mem_clken && mem_chipselect) begin
         ram_a <= mem_address;
         if (mem_write && mem_address < 13'd6250)
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end
   end
   assign mem_readdata = (ram_a < 13'd6250) ? ram[ram_a] : 32'h0;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int done_cnt = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int m; logic [31:0] d; int c;} sb_t;
   sb_t sbq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever any read return strobe appears
   always @(negedge clk) begin
      if (clear_done) done_cnt++;
      if (!reset && (m0_readdatavalid || m1_readdatavalid)) begin
         chk("rdv_exclusive", 32'(m0_readdatavalid & m1_readdatavalid), 32'd0);
         if (sbq.size() == 0) begin
            chk("rdv_unexpected", 32'(m1_readdatavalid), 32'(!m0_readdatavalid));
            n_chk++; n_err++;
            $display("FAIL rdv_unexpected: got valid m0=%0d m1=%0d required none", m0_readdatavalid, m1_readdatavalid);
         end else begin
            sb_t e;
            e = sbq.pop_front();
            chk("rd_owner", 32'(m1_readdatavalid), 32'(e.m));
            chk("rd_latency", 32'(cyc), 32'(e.c));
            chk("rd_data", m1_readdatavalid ? m1_readdata : m0_readdata, e.d);
            chk("rd_other_zero", m1_readdatavalid ? m0_readdata : m1_readdata, 32'h0);
         end
      end
   end

   task automatic drive(input int m, input logic rd, input logic wr, input logic [12:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
      if (m == 0) begin
         m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = wd;
      end else begin
         m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = wd;
      end
   endtask

   task automatic access(input int m, input logic rd, input logic wr, input logic [12:0] a,
                         input logic [3:0] be, input logic [31:0] wd, input logic [31:0] exp);
      bit got = 0;
      drive(m, rd, wr, a, be, wd);
      for (int n = 0; n < 10000 && !got; n++) begin
         @(negedge clk);
         if (((m == 0) ? m0_waitrequest : m1_waitrequest) == 1'b0) begin
            got = 1;
            if (rd && !wr) sbq.push_back('{m, exp, cyc + 1});
         end
         @(posedge clk); #1;
      end
      drive(m, 1'b0, 1'b0, 13'd0, 4'h0, 32'h0);
      if (!got) begin
         n_chk++; n_err++;
         $display("FAIL grant_timeout: master %0d got no grant within budget", m);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
      $fatal(1);
   end

   initial begin
      int busy_cnt;
      int bad_clr;
      reset = 1'b1; clear_req = 1'b0;
      drive(0, 1'b1, 1'b0, 13'd5, 4'hF, 32'h0);
      drive(1, 1'b0, 1'b1, 13'd6, 4'hF, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
      chk("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
      chk("rst_cs", 32'(mem_chipselect), 32'd0);
      chk("rst_mwr", 32'(mem_write), 32'd0);
      chk("rst_clken", 32'(mem_clken), 32'd0);
      chk("rst_busy", 32'(clear_busy), 32'd0);
      chk("rst_done", 32'(clear_done), 32'd0);
      chk("rst_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 32'd0);
      chk("rst_rdata", m0_readdata | m1_readdata, 32'h0);
      chk("rst_range_err", 32'(range_err), 32'd0);
      drive(0, 1'b0, 1'b0, 13'd0, 4'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 13'd0, 4'h0, 32'h0);
      reset = 1'b0;
      #1 chk("clken_after_rst", 32'(mem_clken), 32'd1);
      @(posedge clk); #1;

      // basic write / readback on m0
      access(0, 1'b0, 1'b1, 13'd5, 4'hF, 32'h11223344, 32'h0);
      access(0, 1'b1, 1'b0, 13'd5, 4'hF, 32'h0, 32'h11223344);

      // partial byte-enable write from m1 over a zeroed word
      access(0, 1'b0, 1'b1, 13'd7, 4'hF, 32'h00000000, 32'h0);
      access(1, 1'b0, 1'b1, 13'd7, 4'b0011, 32'hAABBCCDD, 32'h0);
      access(1, 1'b1, 1'b0, 13'd7, 4'hF, 32'h0, 32'h0000CCDD);

      // both masters reading continuously: grants alternate starting with m0
      drive(0, 1'b1, 1'b0, 13'd5, 4'hF, 32'h0);
      drive(1, 1'b1, 1'b0, 13'd7, 4'hF, 32'h0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("alt_m0_wait", 32'(m0_waitrequest), 32'(i % 2));
         chk("alt_m1_wait", 32'(m1_waitrequest), 32'((i + 1) % 2));
         if (!m0_waitrequest) sbq.push_back('{0, 32'h11223344, cyc + 1});
         if (!m1_waitrequest) sbq.push_back('{1, 32'h0000CCDD, cyc + 1});
         @(posedge clk); #1;
      end
      drive(0, 1'b0, 1'b0, 13'd0, 4'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 13'd0, 4'h0, 32'h0);

      // read+write together behaves as a write, with no read return
      access(0, 1'b1, 1'b1, 13'd9, 4'hF, 32'hCAFEF00D, 32'h0);
      @(negedge clk);
      chk("rw_no_rdv", 32'(m0_readdatavalid), 32'd0);
      @(posedge clk); #1;
      access(0, 1'b1, 1'b0, 13'd9, 4'hF, 32'h0, 32'hCAFEF00D);

      // clear sequence with m0 holding a write request
      drive(0, 1'b0, 1'b1, 13'd100, 4'hF, 32'h12345678);
      clear_req = 1'b1;
      @(negedge clk);
      chk("clr_blocks_m0", 32'(m0_waitrequest), 32'd1);
      @(posedge clk); #1;
      clear_req = 1'b0;
      busy_cnt = 0; bad_clr = 0;
      for (int k = 0; k < 7000; k++) begin
         @(negedge clk);
         if (!clear_busy) break;
         if (mem_address != 13'(k) || !mem_write || !mem_chipselect || mem_byteenable != 4'hF ||
             mem_writedata != 32'h0 || !m0_waitrequest || !m1_waitrequest || clear_done)
            bad_clr++;
         busy_cnt++;
         @(posedge clk); #1;
         clear_req = (k == 49);
      end
      clear_req = 1'b0;
      chk("clr_busy_cycles", 32'(busy_cnt), 32'd6250);
      chk("clr_cmd_errors", 32'(bad_clr), 32'd0);
      chk("clr_done_pulse", 32'(clear_done), 32'd1);
      chk("clr_m0_first_grant", 32'(m0_waitrequest), 32'd0);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 13'd0, 4'h0, 32'h0);
      @(negedge clk);
      chk("clr_done_low", 32'(clear_done), 32'd0);
      chk("clr_done_count", 32'(done_cnt), 32'd1);
      @(posedge clk); #1;
      access(1, 1'b1, 1'b0, 13'd6249, 4'hF, 32'h0, 32'h0);
      access(0, 1'b1, 1'b0, 13'd100, 4'hF, 32'h0, 32'h12345678);
      access(0, 1'b1, 1'b0, 13'd5, 4'hF, 32'h0, 32'h0);

      // out-of-range access
      drive(0, 1'b1, 1'b0, 13'd6300, 4'hF, 32'h0);
      @(negedge clk);
      chk("oor_grant", 32'(m0_waitrequest), 32'd0);
`ifdef ONCHIP_MEM_ARB_RANGE_CHECK_EN
      chk("oor_no_cs", 32'(mem_chipselect), 32'd0);
      sbq.push_back('{0, 32'hDEADBEEF, cyc + 1});
`else
      chk("oor_addr_fwd", 32'(mem_address), 32'd6300);
      sbq.push_back('{0, 32'h0, cyc + 1});
`endif
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 13'd0, 4'h0, 32'h0);
      @(negedge clk);
`ifdef ONCHIP_MEM_ARB_RANGE_CHECK_EN
      chk("oor_range_err", 32'(range_err), 32'd1);
`else
      chk("oor_range_err", 32'(range_err), 32'd0);
`endif
      @(posedge clk); #1;

      // reset in the middle of a clear
      clear_req = 1'b1;
      @(posedge clk); #1;
      clear_req = 1'b0;
      repeat (100) @(posedge clk);
      @(negedge clk);
      chk("midclr_addr", 32'(mem_address), 32'd100);
      reset = 1'b1;
      #1;
      chk("midclr_busy_async", 32'(clear_busy), 32'd0);
      chk("midclr_cs", 32'(mem_chipselect), 32'd0);
      chk("midclr_range_err", 32'(range_err), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("midclr_no_done", 32'(done_cnt), 32'd1);

      // after reset m0 wins the first conflict
      drive(0, 1'b1, 1'b0, 13'd6249, 4'hF, 32'h0);
      drive(1, 1'b1, 1'b0, 13'd6249, 4'hF, 32'h0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("post_rst_m0_wait", 32'(m0_waitrequest), 32'(i % 2));
         chk("post_rst_m1_wait", 32'(m1_waitrequest), 32'((i + 1) % 2));
         if (!m0_waitrequest) sbq.push_back('{0, 32'h0, cyc + 1});
         if (!m1_waitrequest) sbq.push_back('{1, 32'h0, cyc + 1});
         @(posedge clk); #1;
      end
      drive(0, 1'b0, 1'b0, 13'd0, 4'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 13'd0, 4'h0, 32'h0);
      access(1, 1'b0, 1'b1, 13'd200, 4'hF, 32'h0BADF00D, 32'h0);
      access(0, 1'b1, 1'b0, 13'd200, 4'hF, 32'h0, 32'h0BADF00D);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 32'(sbq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-master Avalon-MM arbiter in front of the single-port on-chip RAM (6250 x 32, 13-bit word address, byte enables, address registered inside RAM, output unregistered → read data one cycle after command).
- Shares the RAM between the Nios data master (m0) and a DMA/peripheral master (m1) with round-robin fairness.
- Provides a hardware clear sequencer that zero-fills the RAM on request.

Parameters:
- ADDR_W, 13, word address width on both master and memory sides.
- DATA_W, 32, data width; byte enable width is DATA_W/8.
- DEPTH, 6250, number of valid RAM words.
- CLEAR_VALUE, 0, word written to every location by the clear sequencer.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- m0_address  in  ADDR_W  master 0 word address.
- m0_byteenable  in  DATA_W/8  master 0 byte enables.
- m0_read  in  1  master 0 read request.
- m0_write  in  1  master 0 write request.
- m0_writedata  in  DATA_W  master 0 write data.
- m0_waitrequest  out  1  high = command not accepted this cycle.
- m0_readdata  out  DATA_W  read data, valid with m0_readdatavalid, else 0.
- m0_readdatavalid  out  1  one-cycle read return strobe.
- m1_*  (same eight ports as m0_*)  master 1.
- clear_req  in  1  single-cycle pulse that starts the zero-fill.
- clear_busy  out  1  high while the clear sequence runs.
- clear_done  out  1  one-cycle pulse after the last clear write.
- range_err  out  1  sticky out-of-range flag (see Optional Feature).
- mem_address  out  ADDR_W  to RAM.
- mem_byteenable  out  DATA_W/8  to RAM.
- mem_chipselect  out  1  to RAM.
- mem_write  out  1  to RAM.
- mem_writedata  out  DATA_W  to RAM.
- mem_clken  out  1  RAM clock enable; tied 1 except during reset.
- mem_readdata  in  DATA_W  from RAM, valid one cycle after the read command.

Behaviour:
- Reset (async, active-high):
  - State = ARB; rr_last = 1, so m0 wins the first conflict.
  - rd_pend = 0; clear counter = 0; range_err = 0.
  - While reset is asserted: both waitrequests = 1, readdatavalids = 0, readdatas = 0, mem_chipselect = 0, mem_write = 0, mem_clken = 0, clear_busy = 0, clear_done = 0.
- State ARB:
  - A master requests when read or write is high.
  - One requester: it is granted.
  - Both request: grant the master that is not rr_last.
  - rr_last updates on every grant.
  - Grant is combinational in the same cycle: the granted master's waitrequest = 0, the other's = 1.
  - The memory command is muxed from the granted master: mem_chipselect = 1, mem_write = that master's write.
  - No requester: mem_chipselect = 0, both waitrequests = 1.
  - Throughput: one access per cycle; back-to-back grants to alternating or same master allowed.
- Read and write both high on the same master: treated as a write; no readdatavalid is generated.
- Read return:
  - A granted read sets rd_pend = 1 and rd_owner = master id for the next cycle.
  - Next cycle: readdatavalid = 1 for rd_owner only, readdata = mem_readdata.
  - The other master's readdata = 0.
  - Read latency is fixed at 1 cycle and is independent of new grants in the same cycle.
- State CLEAR (entered on clear_req in ARB):
  - clear_busy = 1; both waitrequests = 1.
  - Each cycle write CLEAR_VALUE with all byte enables set to address cnt; cnt runs 0..DEPTH-1.
  - After writing DEPTH-1: pulse clear_done for 1 cycle, return to ARB, cnt = 0.
  - Duration is exactly DEPTH cycles of writes.
  - clear_req in the same cycle as a master request: the clear wins and the request is not granted.
  - A read granted in the cycle before entry still returns its readdatavalid in the first CLEAR cycle.
  - clear_req while in CLEAR is ignored.
- Reset mid-clear: the clear aborts immediately, the pending read is dropped, and the block returns to ARB. Partially cleared memory is acceptable.

Optional Feature:
- Macro: ONCHIP_MEM_ARB_RANGE_CHECK_EN.
- Defined:
  - A granted access with address >= DEPTH is accepted (waitrequest = 0) but not forwarded (mem_chipselect = 0).
  - A write is dropped.
  - A read returns readdatavalid the next cycle with readdata = 32'hDEADBEEF.
  - range_err is set and remains set until reset.
- Undefined: the address is forwarded unchanged and range_err is tied 0.

Test Plan:
- After reset, m0 writes 0x11223344 to addr 5 with byteenable 4'hF, then reads addr 5 → m0_readdatavalid exactly 1 cycle after grant with 0x11223344; m1_readdatavalid stays 0.
- m0 and m1 both read continuously for 6 cycles → grants alternate m0, m1, m0, m1, m0, m1; each readdatavalid is routed to the correct master.
- m1 writes 0xAABBCCDD to addr 7 with byteenable 4'b0011 over a preloaded 0x00000000 → readback 0x0000CCDD.
- clear_req pulse while m0 holds a write request:
  - clear_busy high for 6250 cycles, mem_address 0..6249;
  - clear_done pulses once;
  - m0 is granted in the first ARB cycle after the clear;
  - read of addr 6249 returns 0.
- Reset asserted at clear cnt 100 → clear_busy falls asynchronously, no clear_done, next master access is granted normally.
- With ONCHIP_MEM_ARB_RANGE_CHECK_EN: m0 reads addr 6300 → readdata 0xDEADBEEF, range_err = 1, mem_chipselect stays 0. Without the macro: mem_address = 6300 and range_err = 0.
